// File: rtl/switch_input_ctl.sv
// rtl/switch_input_ctl.sv - synchronized, debounced switch bank with change events, pending mask and irq
module switch_input_ctl #(
    parameter int WIDTH          = 16,
    parameter int SAMPLE_CYCLES  = 50000,
    parameter int STABLE_SAMPLES = 8
) (
    input  logic             clk_cpu_i,
    input  logic             reset_i,
    input  logic [WIDTH-1:0] switch_async_i,
    input  logic             ack_i,
    input  logic [WIDTH-1:0] ack_mask_i,
    output logic [WIDTH-1:0] switch_o,
    output logic [WIDTH-1:0] edge_o,
    output logic [WIDTH-1:0] pending_o,
    output logic             irq_o
);

    localparam int PW = (SAMPLE_CYCLES > 1) ? $clog2(SAMPLE_CYCLES) : 1;
    localparam int CW = (STABLE_SAMPLES > 1) ? $clog2(STABLE_SAMPLES) : 1;
    localparam logic [PW-1:0] PRESC_MAX = PW'(SAMPLE_CYCLES - 1);
    localparam logic [CW-1:0] CNT_MAX   = CW'(STABLE_SAMPLES - 1);

    logic [WIDTH-1:0] sync_q1;
    logic [WIDTH-1:0] sync_w;
    logic [PW-1:0]    presc;
    logic             tick_w;
    logic [CW-1:0]    cnt      [WIDTH];
    logic [CW-1:0]    cnt_next [WIDTH];
    logic [WIDTH-1:0] switch_next;
    logic [WIDTH-1:0] edge_next;
    logic [WIDTH-1:0] pending_next;

    always_comb tick_w = (presc == PRESC_MAX);

    // A sample matching the current level restarts the run, so only an
    // unbroken run of STABLE_SAMPLES differing samples is accepted.
    always_comb begin
        switch_next = switch_o;
        edge_next   = '0;
        for (int i = 0; i < WIDTH; i++) begin
            cnt_next[i] = cnt[i];
            if (tick_w) begin
                if (sync_w[i] == switch_o[i]) begin
                    cnt_next[i] = '0;
                end else if (cnt[i] == CNT_MAX) begin
                    switch_next[i] = sync_w[i];
                    edge_next[i]   = 1'b1;
                    cnt_next[i]    = '0;
                end else begin
                    cnt_next[i] = cnt[i] + 1'b1;
                end
            end
        end
    end

    // A new event on a bit wins over an acknowledge of the same bit.
    always_comb pending_next = (pending_o & ~(ack_i ? ack_mask_i : '0)) | edge_o;

    always_ff @(posedge clk_cpu_i) begin
        if (reset_i) begin
            sync_q1   <= '0;
            sync_w    <= '0;
            presc     <= '0;
            switch_o  <= '0;
            edge_o    <= '0;
            pending_o <= '0;
            irq_o     <= 1'b0;
            for (int i = 0; i < WIDTH; i++) cnt[i] <= '0;
        end else begin
            sync_q1   <= switch_async_i;
            sync_w    <= sync_q1;
            presc     <= tick_w ? '0 : presc + 1'b1;
            switch_o  <= switch_next;
            edge_o    <= edge_next;
            pending_o <= pending_next;
            irq_o     <= |pending_next;
            for (int i = 0; i < WIDTH; i++) cnt[i] <= cnt_next[i];
        end
    end

endmodule

// File: tb/tb_switch_input_ctl.sv
// tb/tb_switch_input_ctl.sv - self-checking bench for switch_input_ctl
module tb_switch_input_ctl;
    localparam int W  = 16;
    localparam int SC = 4;
    localparam int SS = 3;

    logic          clk = 1'b0;
    logic          rst;
    logic [W-1:0]  sw;
    logic          ack;
    logic [W-1:0]  mask;
    logic [W-1:0]  so, eo, po;
    logic          irq;
    logic [W-1:0]  so1, eo1, po1;
    logic          irq1;

    int checks = 0;
    int errors = 0;

    // reference model state
    logic [W-1:0] m_s1 = '0, m_s2 = '0, m_out = '0, m_edge = '0, m_pend = '0;
    int           m_phase = 0;
    int           m_run [W];

    typedef struct {
        logic [W-1:0] sw;
        logic [W-1:0] exp_sw;
        logic [W-1:0] exp_edge;
    } vec_t;
    vec_t tbl [9];

    always #5 clk = ~clk;

    switch_input_ctl #(.WIDTH(W), .SAMPLE_CYCLES(SC), .STABLE_SAMPLES(SS)) dut (
        .clk_cpu_i(clk), .reset_i(rst), .switch_async_i(sw), .ack_i(ack),
        .ack_mask_i(mask), .switch_o(so), .edge_o(eo), .pending_o(po), .irq_o(irq)
    );

    switch_input_ctl #(.WIDTH(W), .SAMPLE_CYCLES(1), .STABLE_SAMPLES(1)) dut1 (
        .clk_cpu_i(clk), .reset_i(rst), .switch_async_i(sw), .ack_i(ack),
        .ack_mask_i(mask), .switch_o(so1), .edge_o(eo1), .pending_o(po1), .irq_o(irq1)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Model: a level is accepted after SS consecutive tick samples that differ from it.
    task automatic model_edge();
        logic [W-1:0] nout, nedge, npend;
        bit tick;
        if (rst) begin
            m_s1 = '0; m_s2 = '0; m_out = '0; m_edge = '0; m_pend = '0; m_phase = 0;
            for (int i = 0; i < W; i++) m_run[i] = 0;
        end else begin
            tick = ((m_phase % SC) == SC - 1);
            m_phase++;
            nout  = m_out;
            nedge = '0;
            if (tick) begin
                for (int i = 0; i < W; i++) begin
                    if (m_s2[i] != m_out[i]) begin
                        m_run[i]++;
                        if (m_run[i] >= SS) begin
                            nout[i]  = m_s2[i];
                            nedge[i] = 1'b1;
                            m_run[i] = 0;
                        end
                    end else begin
                        m_run[i] = 0;
                    end
                end
            end
            npend  = (m_pend & ~(ack ? mask : '0)) | m_edge;
            m_s2   = m_s1;
            m_s1   = sw;
            m_out  = nout;
            m_edge = nedge;
            m_pend = npend;
        end
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        #1;
        chk("model", {so, eo, po, irq}, {m_out, m_edge, m_pend, |m_pend});
    endtask

    initial begin
        int n, e5, e0pre, e0post;
        bit found;
        for (int i = 0; i < W; i++) m_run[i] = 0;

        tbl[0] = '{16'h0000, 16'h0000, 16'h0000};
        tbl[1] = '{16'h00FF, 16'h0000, 16'h0000};
        tbl[2] = '{16'h0F0F, 16'h0000, 16'h0000};
        tbl[3] = '{16'hFFFF, 16'h00FF, 16'h00FF};
        tbl[4] = '{16'h0000, 16'h0F0F, 16'h0FF0};
        tbl[5] = '{16'h1234, 16'hFFFF, 16'hF0F0};
        tbl[6] = '{16'h1234, 16'h0000, 16'hFFFF};
        tbl[7] = '{16'h0000, 16'h1234, 16'h1234};
        tbl[8] = '{16'h0000, 16'h1234, 16'h0000};

        rst = 1'b1; sw = '0; ack = 1'b0; mask = '0;
        repeat (3) step();
        rst = 1'b0;

        // degenerate instance: sample every cycle, accept after one sample
        for (int i = 0; i < 9; i++) begin
            sw = tbl[i].sw;
            step();
            chk("degen_switch", so1, tbl[i].exp_sw);
            chk("degen_edge", eo1, tbl[i].exp_edge);
        end

        // reset with all switches high
        rst = 1'b1; sw = 16'hFFFF;
        for (int i = 0; i < 5; i++) begin
            step();
            chk("reset_outputs", {so, eo, po, irq}, 49'h0);
        end
        rst = 1'b0;
        n = 0; found = 0;
        while (!found && n < 15) begin
            step(); n++;
            if (so == 16'hFFFF) found = 1;
        end
        chk("reset_snapshot_seen", found, 1);
        chk("reset_edge", eo, 16'hFFFF);
        step();
        chk("reset_edge_once", eo, 16'h0000);
        chk("reset_pending", po, 16'hFFFF);
        chk("reset_irq", irq, 1);

        // return to a clean all-low baseline
        sw = '0; ack = 1'b1; mask = 16'hFFFF;
        step();
        ack = 1'b0;
        repeat (25) step();
        ack = 1'b1;
        step();
        ack = 1'b0;
        step();
        chk("baseline", {so, po, irq}, 33'h0);

        // clean step on bit 3
        sw = 16'h0008; n = 0; found = 0;
        while (!found && n < 20) begin
            step(); n++;
            if (so[3]) found = 1;
        end
        chk("step_latency_in_range", (n >= 11 && n <= 15), 1);
        chk("step_switch", so, 16'h0008);
        chk("step_edge", eo, 16'h0008);
        step();
        chk("step_edge_once", eo, 16'h0000);
        chk("step_pending", po, 16'h0008);

        // glitches of 6 and 8 cycles on bit 5
        e5 = 0;
        for (int p = 6; p <= 8; p += 2) begin
            sw = 16'h0028;
            for (int k = 0; k < p; k++) begin step(); if (eo[5]) e5++; end
            sw = 16'h0008;
            for (int k = 0; k < 30; k++) begin step(); if (eo[5]) e5++; end
            chk("glitch_switch", so, 16'h0008);
            chk("glitch_pending", po, 16'h0008);
        end
        chk("glitch_edges", e5, 0);

        // bounce on bit 0 then settle high
        e0pre = 0; e0post = 0;
        for (int t = 0; t < 40; t++) begin
            if (t % 3 == 0) sw[0] = ~sw[0];
            step();
            if (eo[0]) e0pre++;
        end
        sw[0] = 1'b1;
        for (int t = 0; t < 30; t++) begin step(); if (eo[0]) e0post++; end
        chk("bounce_edges_before_settle", e0pre, 0);
        chk("bounce_edges_after_settle", e0post, 1);
        chk("bounce_switch", so, 16'h0009);
        chk("bounce_pending", po, 16'h0009);

        // acknowledge
        ack = 1'b0; mask = 16'hFFFF;
        step();
        chk("ack_ignored", po, 16'h0009);
        ack = 1'b1; mask = 16'h0001;
        step();
        ack = 1'b0;
        chk("ack_bit0", po, 16'h0008);
        chk("ack_bit0_irq", irq, 1);
        ack = 1'b1; mask = 16'h0008;
        step();
        ack = 1'b0;
        chk("ack_bit3", po, 16'h0000);
        chk("ack_bit3_irq", irq, 0);

        // ack colliding with a new edge on bit 2
        sw = 16'h000D; n = 0; found = 0;
        while (!found && n < 20) begin
            step(); n++;
            if (eo[2]) found = 1;
        end
        chk("collision_edge_seen", found, 1);
        ack = 1'b1; mask = 16'h0004;
        step();
        ack = 1'b0;
        chk("collision_pending", po[2], 1);

        // randomized traffic against the model
        for (int c = 0; c < 3000; c++) begin
            if ($urandom_range(0, 99) < 3) sw[$urandom_range(0, W-1)] ^= 1'b1;
            ack  = ($urandom_range(0, 9) == 0);
            mask = W'($urandom);
            rst  = ($urandom_range(0, 499) == 0);
            step();
        end
        rst = 1'b0; ack = 1'b0;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
